fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences instruction fetch from a handshaked, variable-latency instruction memory on behalf of the IF stage. Owns the architectural fetch PC and allows one outstanding request. Applies redirects from EX (branch taken, jal, jalr), stalls from the hazard unit and IF flushes from the control unit. Presents a registered instruction/PC pair to the IF/ID boundary; a flushed slot reads as all-zero instruction.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: IF/ID must hold (inverse of write enable)
flush  in  1  control unit: kill the instruction currently presented
redirect_valid  in  1  EX resolved redirect this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (cannot be back-pressured)
imem_rdata  in  32  instruction word
out_valid  out  1  out_instr/out_pc hold a live instruction
out_instr  out  32  fetched instruction, 32'h0 when not valid
out_pc  out  32  PC of out_instr
pc  out  32  current fetch PC
perf_fetched  out  32  instructions delivered (see Optional Feature)
perf_stall_cyc  out  32  cycles with out_valid && stall (see Optional Feature)

Behaviour:
- States: IDLE, REQ, WAIT, DROP. Reset: state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, imem_req=0, perf counters=0. rst overrides all other inputs in the same cycle.
- IDLE: one cycle, then REQ.
- imem_req = (state==REQ) && (!out_valid || !stall); combinational; imem_addr = pc.
- REQ: on imem_req && imem_ready: req_pc<=pc, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
- WAIT: on imem_rvalid: out_instr<=imem_rdata, out_pc<=req_pc, out_valid<=1, go to REQ.
- The issue rule guarantees the output slot is free or being consumed when data returns; no skid buffer.
- Output consumption: out_valid && !stall consumes the slot. out_valid<=0 unless reloaded the same cycle. out_instr/out_pc hold while stall.
- flush (no redirect): out_valid<=0, out_instr<=0. A WAIT response arriving the same cycle is still loaded (flush only kills the presented slot).
- redirect_valid (priority over flush and stall): pc<=redirect_pc&~3, out_valid<=0, out_instr<=0. Next state:
  - REQ with imem_ready and imem_req this cycle -> DROP (stale request accepted).
  - REQ otherwise -> REQ.
  - WAIT with imem_rvalid -> REQ, data discarded.
  - WAIT without imem_rvalid -> DROP.
  - DROP -> DROP.
  - IDLE -> IDLE.
- DROP: imem_req=0. On imem_rvalid, discard data and go to REQ. A redirect in DROP only updates pc.
- imem_rvalid in IDLE or REQ is ignored.
- Latency with zero-wait memory (ready=1, rvalid one cycle after accept): first imem_req one cycle after reset release; out_valid two cycles after accept. Steady-state throughput is 1 instruction per 2 cycles.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: perf_fetched increments on each consumed slot (out_valid && !stall && !flush && !redirect_valid). perf_stall_cyc increments each cycle out_valid && stall. Both wrap at 2^32 and clear on rst.
- Undefined: both ports tied to 32'h0 and no counter flops are inferred.

Test Plan:
- Reset with RESET_PC=32'h100, ready=1, one-cycle memory -> imem_addr 0x100, 0x104, 0x108 in order; out_pc matches each; out_valid every second cycle.
- Hold stall=1 while out_valid=1 for 5 cycles -> imem_req=0; out_instr/out_pc unchanged. Release stall -> next request at the following pc.
- Redirect to 0x2002 while in WAIT, rvalid arrives 3 cycles later -> that data never appears on out_instr; next imem_addr=0x2000.
- Redirect in the same cycle as imem_rvalid -> data dropped; out_valid=0; next request at the redirect target, with no DROP cycle.
- Assert rst mid-WAIT, then a stale rvalid during IDLE -> ignored; first request at RESET_PC.
- pc=32'hFFFF_FFFC accepted -> pc becomes 0. With FETCH_PERF_CNT_EN defined, after 10 delivered instructions and 4 stall cycles -> perf_fetched=10, perf_stall_cyc=4. Without the macro, both read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer for the IF stage. Owns the architectural fetch
//   PC, issues at most one outstanding request to a handshaked,
//   variable-latency instruction memory, and presents a registered
//   instruction/PC pair to the IF/ID boundary. Redirects from EX, stalls from
//   the hazard unit and flushes from the control unit are applied here. A
//   killed or empty slot always reads as an all-zero instruction.
//
//   Optional build macro:
//     FETCH_PERF_CNT_EN  when defined, perf_fetched / perf_stall_cyc are live
//                        32-bit wrapping counters; otherwise both read 0 and
//                        no counter flops exist.
//
//   Parameters:
//     RESET_PC        fetch PC loaded on reset (bits [1:0] must be 0)
//
//   Ports:
//     clk             clock, all state updates on posedge
//     rst             synchronous active-high reset, overrides everything
//     stall           IF/ID must hold its contents this cycle
//     flush           kill the instruction currently presented
//     redirect_valid  EX resolved a redirect this cycle (highest priority)
//     redirect_pc     redirect target, bits [1:0] ignored
//     imem_req        fetch request (combinational)
//     imem_addr       fetch address, always equal to pc
//     imem_ready      memory accepts the request this cycle
//     imem_rvalid     read data valid, cannot be back-pressured
//     imem_rdata      returned instruction word
//     out_valid       out_instr / out_pc hold a live instruction
//     out_instr       presented instruction, 32'h0 when not valid
//     out_pc          PC of out_instr
//     pc              current fetch PC
//     perf_fetched    instructions consumed by IF/ID
//     perf_stall_cyc  cycles with a live instruction held by stall
// ----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] pc,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cyc
);

   // IDLE : one settling cycle after reset
   // REQ  : ready to issue a request for pc
   // WAIT : one request outstanding, its data will be delivered
   // DROP : one request outstanding, its data is stale and will be discarded
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] req_pc;     // address of the outstanding request
   logic        accept;     // request handshake completes this cycle
   logic        load;       // returning data goes into the output slot

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking assignments so all flops
   // sample the same pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // A redirect during the settling cycle keeps us there one more.
            if (!redirect_valid) state_nxt = REQ;
         end
         REQ: begin
            // A request accepted in a redirect cycle fetched the old path,
            // so its response must be swallowed.
            if (accept) state_nxt = redirect_valid ? DROP : WAIT;
         end
         WAIT: begin
            if (imem_rvalid)         state_nxt = REQ;
            else if (redirect_valid) state_nxt = DROP;
         end
         DROP: begin
            // The outstanding response retires the stale request; a redirect
            // here only moves pc, so rvalid still ends the drop.
            if (imem_rvalid) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   // A new request may only be issued when the output slot is empty or is
   // being consumed this cycle; since the response arrives at least one cycle
   // later, the slot is always free when data returns and no skid buffer is
   // needed.
   always_comb begin
      imem_req = (state == REQ) && (!out_valid || !stall);
   end

   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign load      = (state == WAIT) && imem_rvalid && !redirect_valid;

   // -------------------------------------------------------------------------
   // Fetch PC and outstanding-request address
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
         else if (accept)    pc <= pc + 32'd4;   // wraps 32'hFFFF_FFFC -> 0
         if (accept) req_pc <= pc;
      end
   end

   // -------------------------------------------------------------------------
   // IF/ID output slot
   // -------------------------------------------------------------------------
   // Redirect beats everything; a returning response beats flush because
   // flush only kills what is presented now. The instruction is zeroed
   // whenever the slot empties so an invalid slot always reads as 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else if (redirect_valid) begin
         out_valid <= 1'b0;
         out_instr <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_instr <= imem_rdata;
         out_pc    <= req_pc;
      end else if (flush || (out_valid && !stall)) begin
         out_valid <= 1'b0;
         out_instr <= '0;
      end
   end

   // -------------------------------------------------------------------------
   // Performance counters
   // -------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
   logic consume;

   assign consume = out_valid && !stall && !flush && !redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched   <= '0;
         perf_stall_cyc <= '0;
      end else begin
         if (consume)           perf_fetched   <= perf_fetched + 32'd1;
         if (out_valid && stall) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
   end
`else
   assign perf_fetched   = 32'h0;
   assign perf_stall_cyc = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl (RESET_PC = 32'h100). A behavioural
//   model tracks the fetch PC, whether a request is outstanding, whether its
//   response is to be discarded, and the occupancy of the output slot. Each
//   instruction the model expects to be presented is pushed onto a queue; an
//   independent monitor pops and compares whenever out_valid rises.
//   Inputs are driven on the falling edge; the monitor samples 1 time unit
//   after the rising edge.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] pc;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cyc;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .pc             (pc),
      .perf_fetched   (perf_fetched),
      .perf_stall_cyc (perf_stall_cyc)
   );

   // --------------------------------------------------------------------------
   // Bookkeeping
   // --------------------------------------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: condition not reached within cycle budget (t=%0t)", name, $time);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } slot_t;

   slot_t exp_q[$];

   // --------------------------------------------------------------------------
   // Reference model state
   // --------------------------------------------------------------------------
   bit          m_started;   // past the post-reset settling cycle
   bit          m_busy;      // a request is outstanding
   bit          m_discard;   // the outstanding response is stale
   bit          m_valid;     // output slot occupied
   logic [31:0] m_pc;
   logic [31:0] m_req_pc;
   logic [31:0] m_fetched;
   logic [31:0] m_stall_cyc;

   // Memory: one pending response, latency mem_lat (or random when < 0).
   bit          mem_pend = 1'b0;
   int          mem_cnt  = 0;
   int          mem_lat  = 0;
   logic [31:0] mem_data;

   task automatic model_reset();
      m_started   = 1'b0;
      m_busy      = 1'b0;
      m_discard   = 1'b0;
      m_valid     = 1'b0;
      m_pc        = RST_PC;
      m_req_pc    = '0;
      m_fetched   = '0;
      m_stall_cyc = '0;
   endtask

   // One clock cycle: drive inputs, check combinational outputs and the
   // registered state against the model, then advance the model over the
   // coming rising edge.
   task automatic step(input bit i_rst, input bit i_stall, input bit i_flush,
                       input bit i_redir, input logic [31:0] i_rpc, input bit i_ready);
      bit exp_req;
      bit m_accept;
      bit got;
      @(negedge clk);
      rst            = i_rst;
      stall          = i_stall;
      flush          = i_flush;
      redirect_valid = i_redir;
      redirect_pc    = i_rpc;
      imem_rvalid    = 1'b0;
      imem_rdata     = $urandom;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data;
            mem_pend    = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      imem_ready = i_ready && !mem_pend;
      #1;
      exp_req = m_started && !m_busy && (!m_valid || !i_stall);
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall_cyc", perf_stall_cyc, m_stall_cyc);
`else
      check("perf_fetched", perf_fetched, 32'h0);
      check("perf_stall_cyc", perf_stall_cyc, 32'h0);
`endif
      // Memory reacts to the DUT's handshake.
      if (imem_req && imem_ready) begin
         mem_pend = 1'b1;
         mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
         mem_data = $urandom;
      end
      // Model update for the coming edge.
      if (i_rst) begin
         model_reset();
      end else begin
         m_accept = exp_req && imem_ready;
         got      = m_busy && imem_rvalid;
         if (m_valid && i_stall)                          m_stall_cyc = m_stall_cyc + 1;
         if (m_valid && !i_stall && !i_flush && !i_redir) m_fetched   = m_fetched + 1;
         if (i_redir) begin
            m_valid = 1'b0;
         end else if (got && !m_discard) begin
            m_valid = 1'b1;
            exp_q.push_back('{pc: m_req_pc, instr: imem_rdata});
         end else if (i_flush || !i_stall) begin
            m_valid = 1'b0;
         end
         if (got) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
         end else if (m_busy && i_redir) begin
            m_discard = 1'b1;
         end
         if (m_accept) begin
            m_busy    = 1'b1;
            m_discard = i_redir;
            m_req_pc  = m_pc;
         end
         if (!m_started) m_started = !i_redir;
         if (i_redir)       m_pc = {i_rpc[31:2], 2'b00};
         else if (m_accept) m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 1);
   endtask

   // Run until the model's outstanding state matches (busy, !discard when busy).
   task automatic run_until_busy(input bit want);
      int k = 0;
      while (((m_busy != want) || (want && m_discard)) && k < 50) begin
         step(0, 0, 0, 0, 32'h0, 1);
         k++;
      end
      if ((m_busy != want) || (want && m_discard)) timeout("wait_busy");
   endtask

   // --------------------------------------------------------------------------
   // Monitor: compares every newly presented instruction with the scoreboard
   // --------------------------------------------------------------------------
   bit    prev_valid = 1'b0;
   slot_t cur;

   always @(posedge clk) begin
      #1;
      if (out_valid !== 1'b1) begin
         check("out_instr_when_invalid", out_instr, 32'h0);
      end else if (!prev_valid) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_instr");
         end else begin
            cur = exp_q.pop_front();
            check("out_pc", out_pc, cur.pc);
            check("out_instr", out_instr, cur.instr);
         end
      end else begin
         check("out_pc_hold", out_pc, cur.pc);
         check("out_instr_hold", out_instr, cur.instr);
      end
      check("missed_deliveries", exp_q.size(), 32'h0);
      prev_valid = (out_valid === 1'b1);
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      int n_st;
      int k;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset state, then zero-wait fetch from RESET_PC.
      mem_lat = 0;
      step(1, 0, 0, 0, 32'h0, 1);
      idle(12);

      // Stall while an instruction is presented.
      k = 0;
      while (!m_valid && k < 10) begin idle(1); k++; end
      if (!m_valid) timeout("wait_valid");
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'h0, 1);
      idle(6);

      // Redirect in WAIT with a 3-cycle response: stale data dropped.
      mem_lat = 3;
      run_until_busy(0);
      run_until_busy(1);
      mem_lat = 0;
      step(0, 0, 0, 1, 32'h0000_2002, 1);
      idle(8);

      // Redirect in the same cycle as rvalid: no DROP cycle.
      run_until_busy(0);
      run_until_busy(1);
      step(0, 0, 0, 1, 32'h0000_3000, 1);
      idle(6);

      // Reset mid-WAIT, stale rvalid lands in IDLE.
      mem_lat = 1;
      run_until_busy(0);
      run_until_busy(1);
      step(1, 0, 0, 0, 32'h0, 1);
      mem_lat = 0;
      idle(8);

      // PC wrap at the top of the address space.
      run_until_busy(0);
      step(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
      idle(8);

      // Flush of a presented slot and flush coinciding with returning data.
      for (int i = 0; i < 12; i++) step(0, 0, (i % 3) == 0, 0, 32'h0, 1);

      // Counters: 10 delivered instructions with 4 stall cycles after reset.
      step(1, 0, 0, 0, 32'h0, 1);
      n_st = 0;
      k    = 0;
      while (m_fetched < 10 && k < 200) begin
         if (m_valid && n_st < 4) begin
            n_st++;
            step(0, 1, 0, 0, 32'h0, 1);
         end else begin
            step(0, 0, 0, 0, 32'h0, 1);
         end
         k++;
      end
      if (m_fetched < 10) timeout("wait_fetched");
      @(posedge clk); #2;
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched_10", perf_fetched, 32'd10);
      check("perf_stall_cyc_4", perf_stall_cyc, 32'd4);
`else
      check("perf_fetched_off", perf_fetched, 32'd0);
      check("perf_stall_cyc_off", perf_stall_cyc, 32'd0);
`endif

      // Randomized traffic.
      mem_lat = -1;
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step($urandom_range(0, 127) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 15) == 0,
              tgt,
              $urandom_range(0, 3) != 0);
      end
      mem_lat = 0;
      idle(10);
      @(posedge clk); #2;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
